inst_fetch_unit: RTL
====================

Name: inst_fetch_unit

Overview:
- Consumer side of the PC/next-PC interface: samples the PC register value, issues word reads to instruction memory over a req/gnt/rvalid handshake, and buffers returned instructions for decode.
- Drives PCwrt back to the PC unit, so the PC advances only when a fetch for the current PC has been accepted.
- Sits between the PC unit, instruction memory and decode. Supports variable memory latency and branch/jump flush.

Parameters:
- DEPTH, 2, instruction queue entries (power of two, ≥2).
- AW, 32, address / PC width.

Ports:
- clk  input  1  clock, all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- pc_in  input  AW  current PC register value.
- PCwrt  output  1  PC register load enable.
- flush  input  1  branch/jump redirect, one-cycle pulse.
- mem_req  output  1  fetch request, registered.
- mem_addr  output  AW  fetch address, registered.
- mem_gnt  input  1  memory accepts request this cycle.
- mem_rvalid  input  1  read data valid.
- mem_rdata  input  32  instruction word.
- inst_valid  output  1  queue head valid (count != 0).
- inst  output  32  head instruction.
- inst_pc  output  AW  PC of head instruction.
- inst_ready  input  1  decode consumes head when inst_valid is also high.
- fetch_err  output  1  sticky misaligned-PC flag.

Behaviour:
- Reset (async, any state, mid-transaction included):
  - state=IDLE; queue count=0, pointers=0.
  - mem_req=0, mem_addr=0, fetch_err=0.
  - PCwrt=0, inst_valid=0, inst=0, inst_pc=0.
  - A mem_rvalid arriving after reset is ignored.
- FSM states: IDLE, REQ, WAIT, DROP. At most one outstanding fetch.
- IDLE:
  - If !flush && !fetch_err && count<DEPTH && pc_in[1:0]==0: latch mem_addr=pc_in, go to REQ; mem_req=1 from the next cycle.
  - If pc_in[1:0]!=0 (and no flush): set fetch_err, issue nothing.
- REQ: mem_req=1, mem_addr held stable until mem_gnt.
  - mem_gnt && !flush: PCwrt=1 in the same cycle (combinational); go to WAIT.
  - flush && !mem_gnt: drop request (mem_req=0 next cycle); go to IDLE.
  - flush && mem_gnt: request is committed; go to DROP.
- WAIT:
  - mem_rvalid && !flush: push {mem_addr, mem_rdata}; go to IDLE.
  - flush (with or without mem_rvalid): discard. With mem_rvalid, go to IDLE; without, go to DROP.
- DROP: wait for mem_rvalid, discard the data, go to IDLE. Further flushes stay in DROP.
- PCwrt = (state==REQ && mem_gnt) || flush. The flush term lets the PC unit load the redirect target. PCwrt is never high for more than one cycle per accepted fetch.
- flush also:
  - empties the queue (count=0) in the same edge and overrides any pop;
  - clears fetch_err;
  - blocks a new issue from IDLE that cycle.
- Queue:
  - FIFO with wrap-around pointers of log2(DEPTH) bits.
  - Push and pop in the same cycle leaves count unchanged.
  - Push when full cannot occur, because issue requires count<DEPTH and there is one outstanding fetch.
  - Pop when empty is ignored.
  - No bypass: pushed data is visible on inst/inst_pc the cycle after mem_rvalid.
- Best-case latency (gnt on the first REQ cycle, rvalid one cycle later): IDLE decision at cycle 0, mem_req at cycle 1, PCwrt at cycle 1, rvalid at cycle 2, inst_valid at cycle 3.
- mem_rvalid in IDLE or REQ is ignored. mem_gnt outside REQ is ignored.

Test Plan:
- Reset then pc_in=0x00000000, gnt immediate, rvalid next cycle with rdata=0x20080005. Required: mem_req/mem_addr=0 at cycle 1, PCwrt=1 at cycle 1, inst_valid=1 with inst=0x20080005 and inst_pc=0 at cycle 3.
- inst_ready=0; fetch PCs 0x0 and 0x4. Required: the queue fills to 2, no further mem_req while full. Raising inst_ready pops in order (0x0 then 0x4) and fetching resumes the cycle after the first pop.
- Hold mem_gnt low 3 cycles with pc_in=0x8. Required: mem_req and mem_addr=0x8 stay stable, PCwrt=0 until the gnt cycle, then exactly one PCwrt pulse.
- flush during WAIT (addr 0xC), then rvalid=0xDEADBEEF 2 cycles later. Required: data discarded, inst_valid stays 0, PCwrt=1 on the flush cycle, next fetch uses the new pc_in=0x40.
- pc_in=0x00000006 in IDLE. Required: fetch_err=1, no mem_req. A flush clears fetch_err and fetching resumes at aligned pc_in=0x10.
- Assert reset during WAIT with a queue entry present, then mem_rvalid after reset is released. Required: all outputs 0 immediately, the late rvalid is ignored, and count stays 0.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: samples the PC, issues single word reads over a
// req/gnt/rvalid handshake (one fetch in flight at most), buffers returned
// instructions in a small FIFO for decode and handles branch/jump flushes.
module inst_fetch_unit #(
  parameter int DEPTH = 2,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc_in,
  output logic          PCwrt,
  input  logic          flush,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata,
  output logic          inst_valid,
  output logic [31:0]   inst,
  output logic [AW-1:0] inst_pc,
  input  logic          inst_ready,
  output logic          fetch_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          fetch_err_q, fetch_err_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          push;
  logic          pop;

  logic [31:0]   data_q [DEPTH];
  logic [AW-1:0] pcs_q  [DEPTH];

  // State register: FSM, request registers, sticky error and queue bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      fetch_err_q <= 1'b0;
      count_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      fetch_err_q <= fetch_err_d;
      count_q     <= count_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
    end
  end

  // Queue storage: written only on push; contents are hidden while empty,
  // so they need no reset
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wptr_q] <= mem_rdata;
      pcs_q[wptr_q]  <= mem_addr_q;
    end
  end

  // Next-state logic: fetch FSM, request registers and sticky error
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    fetch_err_d = fetch_err_q;
    push        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush) begin
          if (pc_in[1:0] != 2'b00) begin
            fetch_err_d = 1'b1;
          end else if (!fetch_err_q && (count_q < FULL)) begin
            mem_addr_d = pc_in;
            state_d    = REQ;
          end
        end
      end
      REQ: begin
        // A granted request is committed even under flush, so its data
        // must still be drained in DROP.
        if (flush) begin
          state_d = mem_gnt ? DROP : IDLE;
        end else if (mem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          state_d = mem_rvalid ? IDLE : DROP;
        end else if (mem_rvalid) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      DROP: begin
        if (mem_rvalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      fetch_err_d = 1'b0;
    end
    // mem_req is registered: high exactly while the FSM sits in REQ
    mem_req_d = (state_d == REQ);
  end

  // Queue pointer/count update; flush empties the queue and overrides a pop
  always_comb begin
    pop     = (count_q != '0) && inst_ready && !flush;
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (flush) begin
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
    end
  end

  // Outputs: PC load strobe and queue head presentation
  always_comb begin
    PCwrt      = ((state_q == REQ) && mem_gnt) || flush;
    mem_req    = mem_req_q;
    mem_addr   = mem_addr_q;
    fetch_err  = fetch_err_q;
    inst_valid = (count_q != '0);
    inst       = inst_valid ? data_q[rptr_q] : 32'd0;
    inst_pc    = inst_valid ? pcs_q[rptr_q] : '0;
  end

endmodule
